// File: rtl/arity_sweep_checker.sv
// Exhaustive stimulus sweep: drives every N_IN-bit vector for DWELL cycles,
// compares the masked response on the last dwell cycle and accumulates results.
module arity_sweep_checker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3,
  parameter int DWELL = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             loop,
  input  logic [N_OUT-1:0] resp,
  input  logic [N_OUT-1:0] exp_data,
  input  logic [N_OUT-1:0] cmp_mask,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [N_OUT-1:0] first_fail_resp
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  localparam logic [15:0]     LP_LAST     = 16'(DWELL - 1);
  localparam logic [N_IN-1:0] LP_STIM_MAX = '1;

  state_t           r_state;
  logic [N_IN-1:0]  r_stim;
  logic [15:0]      r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err;
  logic             r_fail_valid;
  logic [N_IN-1:0]  r_ff_vec;
  logic [N_OUT-1:0] r_ff_resp;
  logic             r_drain;
  logic             r_pend;
  logic             r_pend_mis;
  logic [N_IN-1:0]  r_pend_stim;
  logic [N_OUT-1:0] r_pend_resp;

  logic             w_mismatch;
  logic             w_err_inc;
  logic [15:0]      w_err_next;
  logic             w_restart;

  assign w_mismatch = |((resp ^ exp_data) & cmp_mask);
  assign w_err_inc  = r_pend && r_pend_mis && (r_err != '1);
  assign w_err_next = r_err + {15'd0, w_err_inc};
  assign w_restart  = ((r_state == S_IDLE) && start) ||
                      ((r_state == S_DONE) && (start || loop));

  // Compare results are folded into the counters one cycle after the compare
  // cycle; the final vector's fold is the drain cycle before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stim       <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_ff_vec     <= '0;
      r_ff_resp    <= '0;
      r_drain      <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_mis   <= 1'b0;
      r_pend_stim  <= '0;
      r_pend_resp  <= '0;
    end else begin
      r_pend <= 1'b0;
      if (r_pend && r_pend_mis) begin
        r_err <= w_err_next;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_ff_vec     <= r_pend_stim;
          r_ff_resp    <= r_pend_resp;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_restart) begin
            r_state      <= S_APPLY;
            r_stim       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_ff_vec     <= '0;
            r_ff_resp    <= '0;
            r_drain      <= 1'b0;
            r_pend       <= 1'b0;
          end
        end
        S_APPLY: begin
          if (r_drain) begin
            r_state <= S_DONE;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else if (r_cnt == LP_LAST) begin
            r_pend      <= 1'b1;
            r_pend_mis  <= w_mismatch;
            r_pend_stim <= r_stim;
            r_pend_resp <= resp;
            if (r_stim == LP_STIM_MAX) begin
              r_drain <= 1'b1;
            end else begin
              r_stim <= r_stim + 1'b1;
              r_cnt  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim            = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign fail_valid      = r_fail_valid;
  assign first_fail_vec  = r_ff_vec;
  assign first_fail_resp = r_ff_resp;

endmodule
